// File: rtl/mouse_pos_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mouse_pos_buffer: saturating, overwrite-oldest sample FIFO for x/y/button
// Revision: 1.0
// ---------------------------------------------------------------------------
module mouse_pos_buffer #(
  parameter int POS_W = 12,
  parameter int NCH   = 2,
  parameter int DEPTH = 4,
  parameter int X_MAX = 1023,
  parameter int Y_MAX = 767
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [POS_W-1:0]        xpos_in,
  input  logic [NCH*POS_W-1:0]    ypos_in,
  input  logic                    mouse_left_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [POS_W-1:0]        xpos_out,
  output logic [NCH*POS_W-1:0]    ypos_out,
  output logic                    mouse_left_out,
  output logic                    left_press,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = POS_W*(NCH+1)+1;
  localparam logic [AW:0]      LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [POS_W-1:0] X_LIM    = POS_W'(X_MAX);
  localparam logic [POS_W-1:0] Y_LIM    = POS_W'(Y_MAX);

  logic [EW-1:0]        mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [EW-1:0]        hold;
  logic                 prev_left;
  logic [POS_W-1:0]     x_sat;
  logic [NCH*POS_W-1:0] y_sat;
  logic [EW-1:0]        wr_entry;
  logic [EW-1:0]        head;
  logic [EW-1:0]        shown;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 drop;

  assign x_sat = (xpos_in > X_LIM) ? X_LIM : xpos_in;

  for (genvar k = 0; k < NCH; k++) begin : g_ysat
    assign y_sat[k*POS_W +: POS_W] =
      (ypos_in[k*POS_W +: POS_W] > Y_LIM) ? Y_LIM : ypos_in[k*POS_W +: POS_W];
  end

  assign wr_entry  = {mouse_left_in, y_sat, x_sat};
  assign out_valid = (level != '0);
  assign full      = (level == LVL_FULL);
  assign push      = in_valid;
  assign pop       = out_ready & out_valid;
  // a push into a full FIFO without a pop evicts the oldest sample
  assign drop      = push & ~pop & full;

  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      hold       <= '0;
      prev_left  <= 1'b0;
      left_press <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop || drop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop && !full) begin
        level <= level + (AW+1)'(1);
      end else if (pop && !push) begin
        level <= level - (AW+1)'(1);
      end
      if (pop) begin
        hold <= head;
      end
      if (drop) begin
        overflow <= 1'b1;
      end
      if (push) begin
        left_press <= mouse_left_in & ~prev_left;
        prev_left  <= mouse_left_in;
      end else begin
        left_press <= 1'b0;
      end
    end
  end

  // show-ahead head while valid, otherwise the last popped sample
  assign head  = mem[rd_ptr];
  assign shown = out_valid ? head : hold;

  assign xpos_out       = shown[POS_W-1:0];
  assign ypos_out       = shown[EW-2:POS_W];
  assign mouse_left_out = shown[EW-1];

endmodule
`default_nettype wire

// File: tb/tb_mouse_pos_buffer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mouse_pos_buffer: directed + random checks against a queue-based model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_mouse_pos_buffer;

  localparam int POS_W = 12;
  localparam int NCH   = 2;
  localparam int DEPTH = 4;
  localparam int X_MAX = 1023;
  localparam int Y_MAX = 767;
  localparam int EW    = POS_W*(NCH+1)+1;
  localparam int LW    = $clog2(DEPTH)+1;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic [POS_W-1:0]     xpos_in;
  logic [NCH*POS_W-1:0] ypos_in;
  logic                 mouse_left_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [POS_W-1:0]     xpos_out;
  logic [NCH*POS_W-1:0] ypos_out;
  logic                 mouse_left_out;
  logic                 left_press;
  logic [LW-1:0]        level;
  logic                 overflow;

  mouse_pos_buffer #(
    .POS_W(POS_W), .NCH(NCH), .DEPTH(DEPTH), .X_MAX(X_MAX), .Y_MAX(Y_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .xpos_in(xpos_in),
    .ypos_in(ypos_in), .mouse_left_in(mouse_left_in), .out_valid(out_valid),
    .out_ready(out_ready), .xpos_out(xpos_out), .ypos_out(ypos_out),
    .mouse_left_out(mouse_left_out), .left_press(left_press), .level(level),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [EW-1:0] q[$];
  logic [EW-1:0] m_hold;
  logic          m_prev;
  logic          m_press;
  logic          m_ovf;

  function automatic logic [POS_W-1:0] sat(input logic [POS_W-1:0] v, input int lim);
    return (int'(v) > lim) ? POS_W'(lim) : v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic          popped;
    logic [EW-1:0] e;
    if (!rst_n) begin
      q.delete();
      m_hold  = '0;
      m_prev  = 1'b0;
      m_press = 1'b0;
      m_ovf   = 1'b0;
    end else begin
      popped = out_ready && (q.size() > 0);
      if (popped) m_hold = q.pop_front();
      if (in_valid) begin
        if (q.size() == DEPTH) begin
          void'(q.pop_front());
          m_ovf = 1'b1;
        end
        e = {mouse_left_in,
             sat(ypos_in[POS_W +: POS_W], Y_MAX),
             sat(ypos_in[0 +: POS_W], Y_MAX),
             sat(xpos_in, X_MAX)};
        q.push_back(e);
        m_press = mouse_left_in && !m_prev;
        m_prev  = mouse_left_in;
      end else begin
        m_press = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    logic [EW-1:0] e;
    e = (q.size() > 0) ? q[0] : m_hold;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("level", 64'(level), 64'(q.size()));
    chk("xpos_out", 64'(xpos_out), 64'(e[POS_W-1:0]));
    chk("ypos_out", 64'(ypos_out), 64'(e[EW-2:POS_W]));
    chk("mouse_left_out", 64'(mouse_left_out), 64'(e[EW-1]));
    chk("left_press", 64'(left_press), 64'(m_press));
    chk("overflow", 64'(overflow), 64'(m_ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic v, input int x, input int y0, input int y1,
                       input logic l, input logic rdy);
    in_valid      = v;
    xpos_in       = POS_W'(x);
    ypos_in       = {POS_W'(y1), POS_W'(y0)};
    mouse_left_in = l;
    out_ready     = rdy;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 0, 0, 0, 1'b0, rdy);
  endtask

  initial begin
    logic exp_press [5];
    logic lseq [5];
    rst_n = 1'b0;
    idle(1'b0);
    tick();
    tick();
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_xpos", 64'(xpos_out), 64'd0);
    rst_n = 1'b1;

    // 1: single push is visible right after its edge, then held after pop
    drive(1'b1, 100, 200, 300, 1'b0, 1'b0);
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_x", 64'(xpos_out), 64'd100);
    chk("t1_y", 64'(ypos_out), 64'({12'd300, 12'd200}));
    chk("t1_level", 64'(level), 64'd1);
    idle(1'b1);
    tick();
    chk("t1_empty", 64'(out_valid), 64'd0);
    chk("t1_hold_x", 64'(xpos_out), 64'd100);
    chk("t1_hold_y", 64'(ypos_out), 64'({12'd300, 12'd200}));

    // 2: saturation
    drive(1'b1, 2000, 900, 50, 1'b0, 1'b0);
    tick();
    chk("t2_x", 64'(xpos_out), 64'd1023);
    chk("t2_y", 64'(ypos_out), 64'({12'd50, 12'd767}));
    idle(1'b1);
    tick();

    // 3: overflow drops oldest
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, i, 0, 0, 1'b0, 1'b0);
      tick();
    end
    chk("t3_level", 64'(level), 64'd4);
    chk("t3_ovf", 64'(overflow), 64'd1);
    for (int i = 2; i <= 5; i++) begin
      chk("t3_pop_x", 64'(xpos_out), 64'(i));
      idle(1'b1);
      tick();
    end
    chk("t3_empty", 64'(out_valid), 64'd0);

    // 4: full with simultaneous push+pop does not drop
    rst_n = 1'b0;
    idle(1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 5; i <= 8; i++) begin
      drive(1'b1, i, 1, 1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 9, 1, 1, 1'b0, 1'b1);
    tick();
    chk("t4_level", 64'(level), 64'd4);
    chk("t4_ovf", 64'(overflow), 64'd0);
    for (int i = 6; i <= 9; i++) begin
      chk("t4_pop_x", 64'(xpos_out), 64'(i));
      idle(1'b1);
      tick();
    end
    chk("t4_empty", 64'(out_valid), 64'd0);

    // 5: press pulses on accepted rising edges, including through an overflow
    lseq      = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    exp_press = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 10+i, 2, 3, lseq[i], 1'b0);
      tick();
      chk("t5_press", 64'(left_press), 64'(exp_press[i]));
    end
    idle(1'b0);
    tick();
    chk("t5_press_end", 64'(left_press), 64'd0);

    // 6: reset mid-operation wins over push and pop
    rst_n = 1'b0;
    idle(1'b0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 40+i, 41, 42, 1'b1, 1'b0);
      tick();
    end
    chk("t6_level3", 64'(level), 64'd3);
    rst_n = 1'b0;
    drive(1'b1, 50, 51, 52, 1'b1, 1'b1);
    tick();
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_x", 64'(xpos_out), 64'd0);
    chk("t6_y", 64'(ypos_out), 64'd0);
    chk("t6_left", 64'(mouse_left_out), 64'd0);
    chk("t6_press", 64'(left_press), 64'd0);
    chk("t6_ovf", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    drive(1'b1, 60, 61, 62, 1'b1, 1'b0);
    tick();
    chk("t6_after_x", 64'(xpos_out), 64'd60);
    chk("t6_after_press", 64'(left_press), 64'd1);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      drive(1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 4095)),
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 1000)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
